async_fifo_rd_checker: RTL and testbench

Read-side consumer for async_fifo. It sits in the rclk domain and drains a programmed number of words through the r_valid/r_ready handshake. Backpressure is either continuous or LFSR-randomised. Each popped word is checked against an incrementing expected sequence, and the block reports counts, the first mismatch, a timeout and pass/fail to the bench or system controller.

---
 rtl/async_fifo_rd_checker.sv | 120 ++++++++++++
 tb/tb_async_fifo_rd_checker.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/async_fifo_rd_checker.sv
// Read-side consumer for async_fifo: drains a programmed word count,
// checks an incrementing sequence and reports counts, errors and timeout.
module async_fifo_rd_checker #(
    parameter int                    DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] BASE_WORD  = 32'hAAAA_0001,
    parameter int                    CNT_WIDTH  = 16,
    parameter int                    TIMEOUT    = 1024
) (
    input  logic                  rclk,
    input  logic                  rrst,
    input  logic                  start,
    input  logic [CNT_WIDTH-1:0]  num_words,
    input  logic                  stall_mode,
    input  logic [15:0]           seed,
    input  logic                  r_valid,
    input  logic [DATA_WIDTH-1:0] r_data,
    output logic                  r_ready,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic                  timeout,
    output logic [CNT_WIDTH-1:0]  word_count,
    output logic [CNT_WIDTH-1:0]  err_count,
    output logic [CNT_WIDTH-1:0]  first_err_idx,
    output logic [DATA_WIDTH-1:0] first_err_data
);

    localparam int WD_W = $clog2(TIMEOUT + 1);
    localparam logic [15:0] LFSR_INIT = 16'hACE1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                state;
    state_t                state_nxt;
    logic [15:0]           lfsr;
    logic [15:0]           lfsr_nxt;
    logic [DATA_WIDTH-1:0] expected;
    logic [CNT_WIDTH-1:0]  num_lat;
    logic [CNT_WIDTH-1:0]  wc_inc;
    logic [WD_W-1:0]       wd;
    logic                  pop;
    logic                  last_pop;
    logic                  wd_expire;

    // Fibonacci taps 16,14,13,11 in right-shift form; bit 0 gates r_ready
    assign lfsr_nxt  = {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
    assign pop       = r_valid && r_ready;
    assign wc_inc    = word_count + 1'b1;
    assign last_pop  = pop && (wc_inc == num_lat);
    assign wd_expire = !pop && (wd == WD_W'(TIMEOUT - 1));

    always_ff @(posedge rclk) begin
        if (!rrst) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE, DONE: begin
                if (start) state_nxt = (num_words != '0) ? RUN : DONE;
            end
            RUN: begin
                if (last_pop || wd_expire) state_nxt = DONE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        r_ready = (state == RUN) && (!stall_mode || lfsr[0]);
        busy    = (state == RUN);
        done    = (state == DONE);
        pass    = (state == DONE) && (err_count == '0) && !timeout;
    end

    always_ff @(posedge rclk) begin
        if (!rrst) begin
            lfsr           <= LFSR_INIT;
            expected       <= BASE_WORD;
            num_lat        <= '0;
            wd             <= '0;
            timeout        <= 1'b0;
            word_count     <= '0;
            err_count      <= '0;
            first_err_idx  <= '0;
            first_err_data <= '0;
        end else if (state != RUN) begin
            if (start) begin
                lfsr           <= (seed != 16'h0) ? seed : LFSR_INIT;
                expected       <= BASE_WORD;
                num_lat        <= num_words;
                wd             <= '0;
                timeout        <= 1'b0;
                word_count     <= '0;
                err_count      <= '0;
                first_err_idx  <= '0;
                first_err_data <= '0;
            end
        end else begin
            lfsr <= lfsr_nxt;
            if (pop) begin
                if (r_data != expected) begin
                    if (err_count != '1) err_count <= err_count + 1'b1;
                    if (err_count == '0) begin
                        first_err_idx  <= word_count;
                        first_err_data <= r_data;
                    end
                end
                expected   <= expected + 1'b1;
                word_count <= wc_inc;
                wd         <= '0;
            end else begin
                wd <= wd + 1'b1;
                if (wd_expire) timeout <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_async_fifo_rd_checker.sv
// Directed bench for async_fifo_rd_checker with a queue-based FIFO source
// and a cycle model of the consumer's rules.
module tb_async_fifo_rd_checker;

    localparam logic [31:0] BASE = 32'hAAAA_0001;
    localparam int          TMO  = 1024;

    logic        rclk = 1'b0;
    logic        rrst;
    logic        start;
    logic [15:0] num_words;
    logic        stall_mode;
    logic [15:0] seed;
    logic        r_valid;
    logic [31:0] r_data;
    logic        r_ready;
    logic        busy;
    logic        done;
    logic        pass;
    logic        timeout;
    logic [15:0] word_count;
    logic [15:0] err_count;
    logic [15:0] first_err_idx;
    logic [31:0] first_err_data;

    async_fifo_rd_checker dut (
        .rclk(rclk), .rrst(rrst), .start(start), .num_words(num_words),
        .stall_mode(stall_mode), .seed(seed), .r_valid(r_valid),
        .r_data(r_data), .r_ready(r_ready), .busy(busy), .done(done),
        .pass(pass), .timeout(timeout), .word_count(word_count),
        .err_count(err_count), .first_err_idx(first_err_idx),
        .first_err_data(first_err_data)
    );

    always #5 rclk = ~rclk;

    int vectors = 0;
    int miscompares = 0;

    // FIFO contents seen by the consumer; head is q[0]
    logic [31:0] q[$];

    // Model state: 0 idle, 1 run, 2 done
    int          m_st = 0;
    logic [15:0] m_lfsr = 16'hACE1;
    logic [15:0] m_n = 0, m_wc = 0, m_err = 0, m_fidx = 0;
    logic [31:0] m_exp = BASE, m_fdata = 0;
    int          m_idle = 0;
    bit          m_to = 0;
    bit          m_pop;

    logic [63:0] rsig;
    int          rones, rcyc;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] lfsr_step(input logic [15:0] l);
        return {l[0] ^ l[2] ^ l[3] ^ l[5], l[15:1]};
    endfunction

    function automatic bit m_rdy();
        return (m_st == 1) && (!stall_mode || m_lfsr[0]);
    endfunction

    task automatic model_edge();
        bit rdy;
        rdy   = m_rdy();
        m_pop = 0;
        if (!rrst) begin
            m_st = 0; m_lfsr = 16'hACE1; m_exp = BASE; m_idle = 0;
            m_n = 0; m_wc = 0; m_err = 0; m_fidx = 0; m_fdata = 0; m_to = 0;
        end else if (m_st != 1) begin
            if (start) begin
                m_lfsr = (seed != 0) ? seed : 16'hACE1;
                m_exp = BASE; m_n = num_words; m_idle = 0; m_to = 0;
                m_wc = 0; m_err = 0; m_fidx = 0; m_fdata = 0;
                m_st = (num_words != 0) ? 1 : 2;
            end
        end else begin
            m_lfsr = lfsr_step(m_lfsr);
            m_pop  = rdy && r_valid;
            if (m_pop) begin
                if (r_data != m_exp) begin
                    if (m_err == 0) begin
                        m_fidx  = m_wc;
                        m_fdata = r_data;
                    end
                    if (m_err != 16'hFFFF) m_err++;
                end
                m_exp++;
                m_wc++;
                m_idle = 0;
                if (m_wc == m_n) m_st = 2;
            end else begin
                m_idle++;
                if (m_idle == TMO) begin
                    m_to = 1;
                    m_st = 2;
                end
            end
        end
    endtask

    task automatic tick();
        r_valid = (q.size() > 0);
        r_data  = r_valid ? q[0] : 32'h0;
        #1;
        chk("r_ready", r_ready, m_rdy());
        rsig = {rsig[62:0], 1'b0} ^ {63'h0, r_ready} ^ (rsig >> 17);
        rones += int'(r_ready);
        rcyc++;
        model_edge();
        @(posedge rclk);
        #1;
        if (m_pop) void'(q.pop_front());
        chk("busy", busy, m_st == 1);
        chk("done", done, m_st == 2);
        chk("pass", pass, (m_st == 2) && m_err == 0 && !m_to);
        chk("timeout", timeout, m_to);
        chk("word_count", word_count, m_wc);
        chk("err_count", err_count, m_err);
        chk("first_err_idx", first_err_idx, m_fidx);
        chk("first_err_data", first_err_data, m_fdata);
    endtask

    task automatic pulse_start(input logic [15:0] n);
        num_words = n;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input int bound, output int n);
        n = 0;
        while (!done && n < bound) begin
            tick();
            n++;
        end
        chk("done_within_bound", done, 1);
    endtask

    task automatic fill(input logic [31:0] first, input int cnt);
        for (int i = 0; i < cnt; i++) q.push_back(first + 32'(i));
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int          n;
        logic [63:0] sig0;
        rrst = 1'b0; start = 1'b0; num_words = 0; stall_mode = 1'b0;
        seed = 16'h0; r_valid = 1'b0; r_data = 32'h0;
        rsig = 0; rones = 0; rcyc = 0;
        repeat (2) @(posedge rclk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_ready", r_ready, 0);
        chk("rst_wc", word_count, 0);
        rrst = 1'b1;
        tick();

        // In-order drain
        fill(BASE, 3);
        pulse_start(3);
        wait_done(20, n);
        chk("t1_pops", n, 3);
        chk("t1_wc", word_count, 3);
        chk("t1_pass", pass, 1);
        chk("t1_err", err_count, 0);
        chk("t1_ready_off", r_ready, 0);

        // Mismatch capture
        q.push_back(32'hAAAA_0001); q.push_back(32'hDEAD_BEEF);
        q.push_back(32'hAAAA_0003); q.push_back(32'h0000_0000);
        pulse_start(4);
        wait_done(20, n);
        chk("t2_err", err_count, 2);
        chk("t2_idx", first_err_idx, 1);
        chk("t2_data", first_err_data, 32'hDEAD_BEEF);
        chk("t2_pass", pass, 0);

        // LFSR backpressure, twice with identical stimulus
        stall_mode = 1'b1;
        seed = 16'h1234;
        for (int r = 0; r < 2; r++) begin
            rsig = 0; rones = 0; rcyc = 0;
            fill(BASE, 64);
            pulse_start(64);
            wait_done(2000, n);
            chk("t3_wc", word_count, 64);
            chk("t3_pass", pass, 1);
            chk("t3_drained", q.size(), 0);
            chk("t3_toggles", (rones > 0) && (rones < rcyc), 1);
            if (r == 0) sig0 = rsig;
            else chk("t3_repeat_sig", rsig, sig0);
        end
        stall_mode = 1'b0;

        // Watchdog timeout
        fill(BASE, 2);
        pulse_start(5);
        wait_done(3000, n);
        chk("t4_cycles", n, 2 + TMO);
        chk("t4_timeout", timeout, 1);
        chk("t4_pass", pass, 0);
        chk("t4_wc", word_count, 2);

        // Zero-length run from DONE
        pulse_start(0);
        chk("t5_done", done, 1);
        chk("t5_pass", pass, 1);
        chk("t5_wc", word_count, 0);

        // Start during RUN is ignored
        pulse_start(3);
        repeat (3) tick();
        seed = 16'h0001;
        pulse_start(1);
        fill(BASE, 3);
        wait_done(30, n);
        chk("t6_wc", word_count, 3);
        chk("t6_pass", pass, 1);

        // Mid-run reset, then clean restart
        fill(BASE, 5);
        pulse_start(5);
        repeat (2) tick();
        rrst = 1'b0;
        tick();
        chk("t7_busy", busy, 0);
        chk("t7_wc", word_count, 0);
        chk("t7_ready", r_ready, 0);
        chk("t7_no_pop", q.size(), 3);
        rrst = 1'b1;
        q.delete();
        fill(BASE, 3);
        pulse_start(3);
        wait_done(20, n);
        chk("t7_wc2", word_count, 3);
        chk("t7_pass2", pass, 1);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
